prim_cmd_sequencer: RTL and testbench
=====================================

Name: prim_cmd_sequencer

Overview:
- Command queue and sequencer placed in front of the primitive renderer.
- Buffers 16-bit renderer command words from the host register interface and replays them to the renderer's command port in order.
- Holds each execute word, and every word after it, until the renderer is idle. Parameter and color registers are therefore never overwritten while a triangle is being drawn.
- Lets the host queue several primitives without polling busy.

Parameters:
- FIFO_DEPTH, 16, queue depth in words; power of 2, minimum 2.
- EXEC_OP, 4'hF, opcode in cmd[15:12] that starts rendering; must match the renderer's execute opcode.
- START_TIMEOUT, 4, cycles to wait for renderer busy to rise after an execute word is issued.

Ports:
- clk  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- host_cmd_i  in  16  command word from host
- host_cmd_valid_i  in  1  host word valid
- host_cmd_ready_o  out  1  queue can accept a word
- flush_i  in  1  discard all queued words
- prim_cmd_o  out  16  command word to renderer
- prim_cmd_valid_o  out  1  renderer command strobe, one cycle per word
- prim_busy_i  in  1  renderer busy
- level_o  out  $clog2(FIFO_DEPTH)+1  words currently queued
- idle_o  out  1  queue empty, sequencer in S_IDLE and renderer not busy
- exec_count_o  out  16  executes issued (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; reset is asynchronous, active-low (`reset_n_i`).
- Reset values, applied immediately on reset assertion:
  - prim_cmd_o=0, prim_cmd_valid_o=0, level_o=0, exec_count_o=0.
  - state=S_IDLE, FIFO pointers=0.
  - host_cmd_ready_o=1 and idle_o=1 once reset is released (idle_o also requires prim_busy_i=0).
- FIFO:
  - Push when host_cmd_valid_i && host_cmd_ready_o.
  - host_cmd_ready_o = (level_o != FIFO_DEPTH), combinational from registered level.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs prim_cmd_o and prim_cmd_valid_o are registered.
- First-word latency: a word pushed at edge N appears with prim_cmd_valid_o high after edge N+1, provided the sequencer is in S_IDLE and the renderer is not busy.
- States and transitions:
  - S_IDLE, queue non-empty, head opcode != EXEC_OP, prim_busy_i=0: pop, drive word with valid for 1 cycle, stay in S_IDLE. Back-to-back words issue one per cycle.
  - S_IDLE, head opcode == EXEC_OP, prim_busy_i=0: pop, drive word with valid, go to S_WAIT_START, clear timeout counter.
  - S_IDLE, prim_busy_i=1 (e.g. renderer started externally): issue nothing. Non-execute words are also held, because the renderer samples color and destination registers while drawing.
  - S_WAIT_START: prim_busy_i=1 moves to S_WAIT_DONE. Counter reaching START_TIMEOUT with busy still low (degenerate or zero-area primitive) returns to S_IDLE.
  - S_WAIT_DONE: stay while prim_busy_i=1; go to S_IDLE on the first cycle prim_busy_i=0. The next word may issue in the cycle after that return.
- prim_cmd_valid_o is never high outside a pop cycle. prim_cmd_o holds its last value when valid is low.
- Flush:
  - Empties the FIFO on the next edge.
  - A push in the same cycle is dropped (flush wins).
  - Does not abort the renderer. State goes to S_WAIT_DONE if prim_busy_i=1, else S_IDLE. No word issues in the flush cycle.
- Reset asserted mid-render: queue and state are cleared; the renderer's own reset is responsible for the renderer.

Optional Feature:
- Macro PRIM_SEQ_STATS_EN.
- Defined: exec_count_o increments by 1 on each issued execute word. Wraps 16'hFFFF -> 0. Cleared by reset only, not by flush.
- Undefined: exec_count_o is tied to 0 and no counter logic is generated.

Test Plan:
- Reset release with no traffic -> host_cmd_ready_o=1, idle_o=1, level_o=0, prim_cmd_valid_o=0.
- Push 16'h0010, 16'h1020, 16'h6005 back-to-back with renderer idle -> three consecutive prim_cmd_valid_o pulses with the same values and order, the first 2 cycles after the first push; level_o returns to 0.
- Push 16'hF000, then 16'h6003, 16'hF000; renderer model raises busy 2 cycles after the execute word and holds it 50 cycles:
  - 16'h6003 must not appear until busy falls, then issues the next cycle.
  - The second 16'hF000 follows on the cycle after it.
  - exec_count_o=2 with PRIM_SEQ_STATS_EN defined.
- Execute issued with busy never rising -> return to S_IDLE after 4 cycles; the next queued word issues.
- Hold renderer busy and push 17 words (FIFO_DEPTH=16) -> host_cmd_ready_o=0 at level 16, 17th word not accepted; one pop re-asserts ready.
- flush_i pulsed while level_o=5, renderer busy, and a push occurring in the same cycle -> level_o=0 next cycle, pushed word lost, no prim_cmd_valid_o until busy falls and a new word is pushed.

Source files
------------

// File: rtl/prim_cmd_sequencer.sv
// Command queue/sequencer feeding the primitive renderer; holds execute words and all later words while busy.
// Latency: word pushed at edge N issues (registered strobe) after edge N+1 when idle and renderer not busy.
// Backpressure: host_cmd_ready_o drops at FIFO_DEPTH words. Define PRIM_SEQ_STATS_EN for the exec counter.
module prim_cmd_sequencer #(
    parameter int         FIFO_DEPTH    = 16,
    parameter logic [3:0] EXEC_OP       = 4'hF,
    parameter int         START_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset_n_i,
    input  logic [15:0]                   host_cmd_i,
    input  logic                          host_cmd_valid_i,
    output logic                          host_cmd_ready_o,
    input  logic                          flush_i,
    output logic [15:0]                   prim_cmd_o,
    output logic                          prim_cmd_valid_o,
    input  logic                          prim_busy_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          idle_o,
    output logic [15:0]                   exec_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            push, pop;
    logic [15:0]     head;
    logic            head_exec;

    assign host_cmd_ready_o = (level_q != (AW+1)'(FIFO_DEPTH));
    assign push             = host_cmd_valid_i && host_cmd_ready_o && !flush_i;
    assign head             = mem[rd_ptr_q];
    assign head_exec        = (head[15:12] == EXEC_OP);
    assign level_o          = level_q;
    assign idle_o           = (level_q == '0) && (state_q == S_IDLE) && !prim_busy_i;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        if (flush_i) begin
            // Flush never aborts a render in progress; just track it to completion.
            state_d = prim_busy_i ? S_WAIT_DONE : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if ((level_q != '0) && !prim_busy_i) begin
                        pop = 1'b1;
                        if (head_exec) begin
                            state_d = S_WAIT_START;
                            tmo_d   = '0;
                        end
                    end
                end
                S_WAIT_START: begin
                    if (prim_busy_i) begin
                        state_d = S_WAIT_DONE;
                    end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!prim_busy_i) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= host_cmd_i;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prim_cmd_o       <= '0;
            prim_cmd_valid_o <= 1'b0;
        end else begin
            prim_cmd_valid_o <= pop;
            if (pop) prim_cmd_o <= head;
        end
    end

`ifdef PRIM_SEQ_STATS_EN
    logic [15:0] exec_cnt_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            exec_cnt_q <= '0;
        end else if (pop && head_exec) begin
            exec_cnt_q <= exec_cnt_q + 16'd1;
        end
    end

    assign exec_count_o = exec_cnt_q;
`else
    assign exec_count_o = '0;
`endif

endmodule

// File: tb/tb_prim_cmd_sequencer.sv
// Bench for prim_cmd_sequencer: directed plus random traffic checked against a queue-based model.
module tb_prim_cmd_sequencer;
    localparam int DEPTH = 16;
    localparam int TMO   = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] host_cmd = '0;
    logic        host_cmd_valid = 1'b0;
    logic        host_cmd_ready;
    logic        flush = 1'b0;
    logic [15:0] prim_cmd;
    logic        prim_cmd_valid;
    logic        busy = 1'b0;
    logic [4:0]  level;
    logic        idle;
    logic [15:0] exec_count;

    prim_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .EXEC_OP(4'hF), .START_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .reset_n_i        (reset_n),
        .host_cmd_i       (host_cmd),
        .host_cmd_valid_i (host_cmd_valid),
        .host_cmd_ready_o (host_cmd_ready),
        .flush_i          (flush),
        .prim_cmd_o       (prim_cmd),
        .prim_cmd_valid_o (prim_cmd_valid),
        .prim_busy_i      (busy),
        .level_o          (level),
        .idle_o           (idle),
        .exec_count_o     (exec_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending words plus "waiting for render to start/finish" flags.
    logic [15:0] mq[$];
    bit          m_armed, m_drawing;
    int          m_age;
    logic [15:0] m_cmd;
    bit          m_vld;
    logic [15:0] m_execs;

    // Renderer model driving busy.
    bit ext_busy;
    int ren_mode;            // 0: never starts, 1: fixed timing, 2: random timing
    int ren_fix_dly, ren_fix_len;
    int ren_dly, ren_len, ren_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed = 0; m_drawing = 0; m_age = 0;
        m_cmd = '0; m_vld = 0; m_execs = '0;
        ren_dly = 0; ren_len = 0; ren_pend = 0;
    endtask

    task automatic check_outputs();
        logic [15:0] exp_cnt;
`ifdef PRIM_SEQ_STATS_EN
        exp_cnt = m_execs;
`else
        exp_cnt = '0;
`endif
        chk("valid", 32'(prim_cmd_valid), 32'(m_vld));
        chk("cmd",   32'(prim_cmd),       32'(m_cmd));
        chk("level", 32'(level),          32'(mq.size()));
        chk("ready", 32'(host_cmd_ready), 32'(mq.size() != DEPTH));
        chk("idle",  32'(idle),           32'(mq.size() == 0 && !m_armed && !m_drawing && !busy));
        chk("execs", 32'(exec_count),     32'(exp_cnt));
    endtask

    // One clock: model predicts from the inputs in force this cycle, then compares after the edge.
    task automatic step();
        bit rdy, iss, pre_armed, pre_draw;
        int d, l;
        logic [15:0] w;
        busy      = ext_busy || (ren_len > 0);
        pre_armed = m_armed;
        pre_draw  = m_drawing;
        rdy = (mq.size() != DEPTH);
        iss = !flush && !pre_armed && !pre_draw && (mq.size() > 0) && !busy;
        @(posedge clk);
        #1;
        m_vld = 0;
        if (flush) begin
            mq.delete();
            m_armed   = 0;
            m_drawing = busy;
        end else begin
            if (pre_armed) begin
                if (busy) begin
                    m_armed = 0; m_drawing = 1;
                end else begin
                    m_age++;
                    if (m_age == TMO) m_armed = 0;
                end
            end
            if (pre_draw && !busy) m_drawing = 0;
            if (iss) begin
                w = mq.pop_front();
                m_cmd = w; m_vld = 1;
                if (w[15:12] == 4'hF) begin
                    m_armed = 1; m_age = 0; m_execs = m_execs + 16'd1;
                end
            end
            if (host_cmd_valid && rdy) mq.push_back(host_cmd);
        end
        check_outputs();
        if (ren_len > 0) ren_len--;
        if (ren_dly > 0) begin
            ren_dly--;
            if (ren_dly == 0) ren_len = ren_pend;
        end
        if (m_vld && m_cmd[15:12] == 4'hF && ren_mode != 0) begin
            d = (ren_mode == 1) ? ren_fix_dly : $urandom_range(0, 2);
            l = (ren_mode == 1) ? ren_fix_len : $urandom_range(1, 8);
            if (d != 0) begin
                ren_dly = d; ren_pend = l;
            end
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        host_cmd_valid = 1'b1;
        host_cmd = w;
        step();
        host_cmd_valid = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        host_cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        ext_busy = 0; ren_mode = 0; ren_fix_dly = 0; ren_fix_len = 0;
        model_reset();

        // Reset values while reset is held, then after release.
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(prim_cmd_valid), 32'd0);
        chk("rst_cmd",   32'(prim_cmd), 32'd0);
        chk("rst_execs", 32'(exec_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_ready", 32'(host_cmd_ready), 32'd1);
        chk("rel_idle",  32'(idle), 32'd1);
        idle_steps(2);

        // Back-to-back plain words.
        push_word(16'h0010);
        push_word(16'h1020);
        push_word(16'h6005);
        idle_steps(4);

        // Execute, then a register write and a second execute held behind the render.
        ren_mode = 1; ren_fix_dly = 2; ren_fix_len = 50;
        push_word(16'hF000);
        push_word(16'h6003);
        push_word(16'hF000);
        idle_steps(120);

        // Execute whose render never starts: start timeout releases the queue.
        ren_mode = 0;
        push_word(16'hF000);
        push_word(16'h0111);
        idle_steps(10);

        // Fill while the renderer is busy; the 17th word is refused.
        ext_busy = 1;
        for (int i = 0; i < DEPTH + 1; i++) push_word({4'($urandom_range(0, 14)), 12'($urandom)});
        ext_busy = 0;
        idle_steps(1);
        idle_steps(40);

        // Flush with five queued words, busy renderer, and a colliding push.
        ext_busy = 1;
        for (int i = 0; i < 5; i++) push_word({4'($urandom_range(0, 14)), 12'($urandom)});
        flush = 1'b1;
        push_word(16'h2222);
        flush = 1'b0;
        idle_steps(3);
        ext_busy = 0;
        idle_steps(3);
        push_word(16'h3333);
        idle_steps(3);

        // Random traffic with a randomly timed renderer.
        ren_mode = 2;
        for (int i = 0; i < 600; i++) begin
            host_cmd_valid = ($urandom_range(0, 2) != 0);
            host_cmd = {($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
            flush = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) ext_busy = !ext_busy;
            step();
        end
        flush = 1'b0;
        ext_busy = 0;

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 4; i++) push_word({4'($urandom_range(0, 14)), 12'($urandom)});
        reset_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(prim_cmd_valid), 32'd0);
        chk("mid_rst_execs", 32'(exec_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        push_word(16'h0ABC);
        idle_steps(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
